// File: rtl/adder_pkg.sv
// Shared constants, helpers and stage control record for the pipelined add/subtract unit.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned chunk_w(int unsigned width, int unsigned stages);
    return width / stages;
  endfunction

  // Width-independent part of a stage record; operand remainders and the sum
  // accumulator depend on the stage index and are declared per stage in the top.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry slice; each full adder is two half adders plus an OR.
module adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic s1;
    logic c1;
    logic c2;
    half_adder u_ha0 (.a_i(a[i]), .b_i(b[i]), .s_o(s1),   .c_o(c1));
    half_adder u_ha1 (.a_i(s1),   .b_i(c[i]), .s_o(s[i]), .c_o(c2));
    assign c[i+1] = c1 | c2;
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell, the building block of every carry slice.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: STAGES carry slices, one register per slice,
// valid/ready on both sides with a single global advance enable.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

  if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_x;
  logic             ovf_d;
  logic             ovf_q;

  // The whole pipe moves as one shift register; bubbles are held like beats.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_x      = (in_sub == OP_ADD) ? in_b : ~in_b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO     = k * CHUNK;
    localparam int unsigned DONE_W = LO + CHUNK;

    logic [CHUNK-1:0]  a_c;
    logic [CHUNK-1:0]  b_c;
    logic [CHUNK-1:0]  s_c;
    logic              cin_c;
    logic              cout_c;
    logic              c_msb_c;
    logic              src_valid_c;
    logic [DONE_W-1:0] sum_d;
    logic [DONE_W-1:0] sum_q;
    stage_ctl_t        ctl_d;
    stage_ctl_t        ctl_q;

    if (k == 0) begin : g_src
      assign a_c         = in_a[CHUNK-1:0];
      assign b_c         = b_x[CHUNK-1:0];
      assign cin_c       = (in_sub == OP_SUB);
      assign src_valid_c = in_valid;
      assign sum_d       = s_c;
    end else begin : g_src
      assign a_c         = g_stage[k-1].g_rem.a_rem_q[CHUNK-1:0];
      assign b_c         = g_stage[k-1].g_rem.b_rem_q[CHUNK-1:0];
      assign cin_c       = g_stage[k-1].ctl_q.carry;
      assign src_valid_c = g_stage[k-1].ctl_q.valid;
      assign sum_d       = {s_c, g_stage[k-1].sum_q};
    end

    // Operand bits for the slices still ahead travel alongside the partial sum.
    if (k < STAGES - 1) begin : g_rem
      localparam int unsigned REM_W = WIDTH - DONE_W;
      logic [REM_W-1:0] a_rem_d;
      logic [REM_W-1:0] b_rem_d;
      logic [REM_W-1:0] a_rem_q;
      logic [REM_W-1:0] b_rem_q;

      if (k == 0) begin : g_in
        assign a_rem_d = in_a[WIDTH-1:CHUNK];
        assign b_rem_d = b_x[WIDTH-1:CHUNK];
      end else begin : g_in
        assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[WIDTH-LO-1:CHUNK];
        assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[WIDTH-LO-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end else begin : g_last
      logic unused_msb;
      assign unused_msb = c_msb_c;
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a        (a_c),
      .b        (b_c),
      .cin      (cin_c),
      .s        (s_c),
      .cout     (cout_c),
      .c_msb_in (c_msb_c)
    );

    always_comb begin
      ctl_d       = '0;
      ctl_d.valid = src_valid_c;
      ctl_d.carry = cout_c;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (advance) begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end
  end

  // Signed overflow needs the carry into the MSB, only visible in the last slice.
  assign ovf_d = g_stage[STAGES-1].c_msb_c ^ g_stage[STAGES-1].cout_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].ctl_q.valid;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].ctl_q.carry;
  assign out_ovf   = ovf_q;

`ifdef FORMAL
  logic [WIDTH-1:0] shadow_q [STAGES];

  always_ff @(posedge clk) begin
    if (advance) begin
      shadow_q[0] <= (in_sub == OP_SUB) ? in_a - in_b : in_a + in_b;
      for (int k = 1; k < STAGES; k++) shadow_q[k] <= shadow_q[k-1];
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable(out_sum) && $stable(out_cout) && $stable(out_ovf));
  a_sum: assert property (@(posedge clk) disable iff (rst) out_valid |-> out_sum == shadow_q[STAGES-1]);
  a_rst: assert property (@(posedge clk) rst |=> !out_valid);
  c_ovf_drain: cover property (@(posedge clk) out_valid && out_ready && out_ovf && g_stage[0].ctl_q.valid);
`endif

endmodule
